// File: rtl/rr_channel_arbiter_if.sv
// Request/grant bundle between N requesters and the round-robin channel arbiter.
// Requesters use the master side and the arbiter uses the slave side.
interface rr_channel_arbiter_if #(
  parameter int N = 4
);
  localparam int OWNER_W = $clog2(N);

  logic [N-1:0]       req;
  logic [N-1:0]       din;
  logic [N-1:0]       gnt;
  logic [OWNER_W-1:0] owner;
  logic               busy;
  logic               o;

  modport master (output req, din, input gnt, owner, busy, o);
  modport slave  (input req, din, output gnt, owner, busy, o);
endinterface

// File: rtl/rr_channel_arbiter.sv
// Round-robin owner selection with a hold limit for a shared one-bit channel.
// A release hands ownership directly to the next requester, with no idle cycle in between.
module rr_channel_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_channel_arbiter_if.slave  ch
);
  localparam int OW     = $clog2(N);
  localparam int HOLD_W = 8;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t              state_p0, state_d;
  logic [OW-1:0]       ptr_p0, ptr_d;
  logic [OW-1:0]       owner_p0, owner_d;
  logic [HOLD_W-1:0]   hold_p0, hold_d;
  logic [N-1:0]        gnt_p0, gnt_d;
  logic                o_p0, o_d;

  // First set bit of cand, scanning start, start+1, ... and wrapping mod N.
  function automatic logic [OW-1:0] rr_pick(input logic [N-1:0] cand,
                                            input logic [OW-1:0] start);
    logic [OW-1:0] pick;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(start) + k) % N;
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = OW'(idx);
      end
    end
    return pick;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [OW-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [OW-1:0] ptr_after(input logic [OW-1:0] idx);
    return (idx == OW'(N - 1)) ? '0 : idx + OW'(1);
  endfunction

  always_comb begin
    state_d = state_p0;
    ptr_d   = ptr_p0;
    owner_d = owner_p0;
    hold_d  = hold_p0;
    gnt_d   = gnt_p0;
    o_d     = 1'b0;
    case (state_p0)
      IDLE: begin
        if (|ch.req) begin
          owner_d = rr_pick(ch.req, ptr_p0);
          gnt_d   = onehot(owner_d);
          hold_d  = '0;
          state_d = OWN;
        end
      end
      OWN: begin
        o_d    = ch.din[owner_p0];
        hold_d = hold_p0 + HOLD_W'(1);
        if (!ch.req[owner_p0] || (hold_p0 == HOLD_LAST)) begin
          ptr_d = ptr_after(owner_p0);
          // A dropped owner is already absent from req; a timed-out owner is
          // still eligible and is reached last because the scan starts past it.
          if (|ch.req) begin
            owner_d = rr_pick(ch.req, ptr_d);
            gnt_d   = onehot(owner_d);
            hold_d  = '0;
          end else begin
            gnt_d   = '0;
            hold_d  = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered stage: ownership state and the channel bit
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= IDLE;
      ptr_p0   <= '0;
      owner_p0 <= '0;
      hold_p0  <= '0;
      gnt_p0   <= '0;
      o_p0     <= 1'b0;
    end else begin
      state_p0 <= state_d;
      ptr_p0   <= ptr_d;
      owner_p0 <= owner_d;
      hold_p0  <= hold_d;
      gnt_p0   <= gnt_d;
      o_p0     <= o_d;
    end
  end

  assign ch.gnt   = gnt_p0;
  assign ch.owner = owner_p0;
  assign ch.busy  = |gnt_p0;
  assign ch.o     = o_p0;
endmodule

// File: tb/tb_rr_channel_arbiter.sv
// Directed bench for rr_channel_arbiter (N=4, MAX_HOLD=8) with hand-computed expectations.
module tb_rr_channel_arbiter;
  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  rr_channel_arbiter_if #(.N(4)) ch ();

  rr_channel_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clk (clk),
    .rst (rst),
    .ch  (ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] dseq;
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    ch.req   = 4'b1111;
    ch.din   = 4'b0000;

    // Reset held for two cycles while everyone requests
    tick();
    tick();
    chk("rst_gnt",   32'(ch.gnt),   32'h0);
    chk("rst_busy",  32'(ch.busy),  32'h0);
    chk("rst_o",     32'(ch.o),     32'h0);
    chk("rst_owner", 32'(ch.owner), 32'h0);

    // Rotation: all request, each owner keeps gnt exactly 8 cycles back to back
    rst = 1'b0;
    tick();
    for (int t = 0; t < 40; t++) begin
      chk("rot_gnt",  32'(ch.gnt),  32'(1 << ((t / 8) % 4)));
      chk("rot_busy", 32'(ch.busy), 32'h1);
      tick();
    end

    // Single requester with din[2] stream 0,1,1,0
    rst    = 1'b1;
    ch.req = 4'b0000;
    tick();
    chk("rst2_gnt", 32'(ch.gnt), 32'h0);
    rst    = 1'b0;
    ch.req = 4'b0100;
    tick();
    chk("single_gnt",   32'(ch.gnt),   32'h4);
    chk("single_owner", 32'(ch.owner), 32'h2);
    chk("single_o0",    32'(ch.o),     32'h0);
    dseq = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      ch.din[2] = dseq[i];
      tick();
      chk("single_o", 32'(ch.o), 32'(dseq[i]));
      chk("single_hold_gnt", 32'(ch.gnt), 32'h4);
    end
    ch.req = 4'b0000;
    tick();
    chk("drop_gnt",  32'(ch.gnt),  32'h0);
    chk("drop_busy", 32'(ch.busy), 32'h0);
    tick();
    chk("idle_o", 32'(ch.o), 32'h0);

    // Early release: owner 0 leaves after 3 cycles, requester 3 takes over on the same edge
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    ch.req = 4'b1001;
    tick();
    chk("early_gnt0", 32'(ch.gnt), 32'h1);
    tick();
    tick();
    chk("early_gnt2", 32'(ch.gnt), 32'h1);
    ch.din = 4'b0001;
    ch.req = 4'b1000;
    tick();
    chk("handoff_gnt",   32'(ch.gnt),   32'h8);
    chk("handoff_busy",  32'(ch.busy),  32'h1);
    chk("handoff_owner", 32'(ch.owner), 32'h3);
    chk("handoff_o_old", 32'(ch.o),     32'h1);
    tick();
    chk("handoff_o_new", 32'(ch.o), 32'h0);
    ch.req = 4'b1010;
    tick();
    chk("nonowner_req_gnt", 32'(ch.gnt), 32'h8);
    ch.req = 4'b0000;
    tick();
    chk("early_idle_busy", 32'(ch.busy), 32'h0);
    ch.din = 4'b0000;

    // Sole requester: timeout re-grants the same owner with no gap
    ch.req = 4'b0010;
    tick();
    for (int t = 0; t < 20; t++) begin
      chk("sole_gnt",  32'(ch.gnt),  32'h2);
      chk("sole_busy", 32'(ch.busy), 32'h1);
      tick();
    end
    chk("sole_owner", 32'(ch.owner), 32'h1);

    // Reset mid-ownership of requester 2, then ptr must scan from 0 again
    ch.req = 4'b0000;
    tick();
    ch.req = 4'b0100;
    tick();
    chk("mid_owner", 32'(ch.owner), 32'h2);
    chk("mid_gnt",   32'(ch.gnt),   32'h4);
    rst    = 1'b1;
    ch.req = 4'b0110;
    tick();
    chk("midrst_gnt",   32'(ch.gnt),   32'h0);
    chk("midrst_busy",  32'(ch.busy),  32'h0);
    chk("midrst_owner", 32'(ch.owner), 32'h0);
    rst = 1'b0;
    tick();
    chk("after_rst_gnt",   32'(ch.gnt),   32'h2);
    chk("after_rst_owner", 32'(ch.owner), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
